seg_scan_mux: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment display driver; next generation of the 4-digit scanner.

---
 rtl/seg_scan_mux_if.sv | 32 +++
 rtl/seg_scan_mux.sv | 179 +++++++++++++++++
 tb/tb_seg_scan_mux.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_mux_if.sv
// Bus bundle between the display datapath and the segment scanner.
// Optional blink_mask member exists only when DISP_BLINK_EN is defined.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    lz_suppress;
`ifdef DISP_BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;
`endif
  logic [6:0]              dispDigit;
  logic                    dispDP;
  logic [NUM_DIGITS-1:0]   selector;
  logic                    scan_tick;

  modport master (
`ifdef DISP_BLINK_EN
    output blink_mask,
`endif
    output digits, dp, lz_suppress,
    input  dispDigit, dispDP, selector, scan_tick
  );

  modport slave (
`ifdef DISP_BLINK_EN
    input  blink_mask,
`endif
    input  digits, dp, lz_suppress,
    output dispDigit, dispDP, selector, scan_tick
  );
endinterface

// File: rtl/seg_scan_mux.sv
// N-digit multiplexed 7-segment scanner with blanking guard, frame-coherent capture,
// leading-zero suppression and selectable polarity. Define DISP_BLINK_EN to add per-digit blink.
module seg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 16384,
  parameter int BLANK_GUARD = 16,
  parameter bit ACTIVE_LOW  = 1'b1
`ifdef DISP_BLINK_EN
  ,
  parameter int BLINK_DIV   = 32
`endif
) (
  input  logic          CLK,
  input  logic          RESET,
  seg_scan_mux_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  function automatic logic [6:0] decode7(input logic [3:0] d);
    case (d)
      4'h0:    decode7 = 7'b0111111;
      4'h1:    decode7 = 7'b0000110;
      4'h2:    decode7 = 7'b1011011;
      4'h3:    decode7 = 7'b1001111;
      4'h4:    decode7 = 7'b1100110;
      4'h5:    decode7 = 7'b1101101;
      4'h6:    decode7 = 7'b1111101;
      4'h7:    decode7 = 7'b0000111;
      4'h8:    decode7 = 7'b1111111;
      4'h9:    decode7 = 7'b1101111;
      4'hA:    decode7 = 7'b1000000;
      default: decode7 = 7'b0000000;
    endcase
  endfunction

  logic                    start_reg;
  logic [PW-1:0]           presc_reg, presc_next;
  logic [IW-1:0]           index_reg, index_next;
  logic [4*NUM_DIGITS-1:0] digits_reg, digits_next;
  logic [NUM_DIGITS-1:0]   dp_reg, dp_next;
  logic                    lz_reg, lz_next;
  logic                    wrap, frame_end, capture;
  logic [NUM_DIGITS-1:0]   hidden;

  logic [6:0]              seg_reg;
  logic                    dp_out_reg;
  logic [NUM_DIGITS-1:0]   selector_reg;
  logic                    tick_reg;

  // start_reg marks the single cycle after reset release: it loads the shadow
  // registers and primes the outputs for prescaler 0 of slot 0.
  always_comb begin
    wrap      = (presc_reg == PW'(SCAN_DIV - 1));
    frame_end = wrap && (index_reg == IW'(NUM_DIGITS - 1));
    capture   = start_reg || frame_end;
    presc_next = wrap ? '0 : presc_reg + PW'(1);
    index_next = index_reg;
    if (frame_end)
      index_next = '0;
    else if (wrap)
      index_next = index_reg + IW'(1);
    if (start_reg) begin
      presc_next = '0;
      index_next = '0;
    end
    digits_next = capture ? bus.digits      : digits_reg;
    dp_next     = capture ? bus.dp          : dp_reg;
    lz_next     = capture ? bus.lz_suppress : lz_reg;
  end

`ifdef DISP_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [FW-1:0]         frame_reg, frame_next;
  logic                  blink_on_reg, blink_on_next;
  logic [NUM_DIGITS-1:0] mask_reg, mask_next;

  always_comb begin
    frame_next    = frame_reg;
    blink_on_next = blink_on_reg;
    if (start_reg) begin
      frame_next    = '0;
      blink_on_next = 1'b1;
    end else if (frame_end) begin
      if (frame_reg == FW'(BLINK_DIV - 1)) begin
        frame_next    = '0;
        blink_on_next = ~blink_on_reg;
      end else begin
        frame_next = frame_reg + FW'(1);
      end
    end
    mask_next = capture ? bus.blink_mask : mask_reg;
    hidden    = blink_on_next ? '0 : mask_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_reg    <= '0;
      blink_on_reg <= 1'b1;
      mask_reg     <= '0;
    end else begin
      frame_reg    <= frame_next;
      blink_on_reg <= blink_on_next;
      mask_reg     <= mask_next;
    end
  end
`else
  assign hidden = '0;
`endif

  // zero_from[i]: shadow digits i..NUM_DIGITS-1 are all zero
  logic [NUM_DIGITS-1:0] zero_from;
  always_comb begin
    logic run;
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run && (digits_next[4*i +: 4] == 4'd0);
      zero_from[i] = run;
    end
  end

  logic [6:0]            seg_all [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_all;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic suppress;
    if (gi == 0) begin : g_lsd
      assign suppress = 1'b0;
    end else begin : g_upper
      assign suppress = lz_next && zero_from[gi];
    end
    assign seg_all[gi] = (suppress || hidden[gi]) ? 7'd0 : decode7(digits_next[4*gi +: 4]);
    assign dp_all[gi]  = dp_next[gi] && !hidden[gi];
  end

  logic [6:0]            seg_pick;
  logic                  dp_pick;
  logic [NUM_DIGITS-1:0] sel_pick;

  always_comb begin
    seg_pick = seg_all[index_next];
    dp_pick  = dp_all[index_next];
    sel_pick = '0;
    if (presc_next >= PW'(BLANK_GUARD))
      sel_pick = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << index_next;
  end

  // Outputs are registered from next-state so they line up with the prescaler.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      start_reg    <= 1'b1;
      presc_reg    <= '0;
      index_reg    <= '0;
      digits_reg   <= '0;
      dp_reg       <= '0;
      lz_reg       <= 1'b0;
      seg_reg      <= {7{ACTIVE_LOW}};
      dp_out_reg   <= ACTIVE_LOW;
      selector_reg <= {NUM_DIGITS{ACTIVE_LOW}};
      tick_reg     <= 1'b0;
    end else begin
      start_reg    <= 1'b0;
      presc_reg    <= presc_next;
      index_reg    <= index_next;
      digits_reg   <= digits_next;
      dp_reg       <= dp_next;
      lz_reg       <= lz_next;
      seg_reg      <= ACTIVE_LOW ? ~seg_pick : seg_pick;
      dp_out_reg   <= ACTIVE_LOW ? ~dp_pick : dp_pick;
      selector_reg <= ACTIVE_LOW ? ~sel_pick : sel_pick;
      tick_reg     <= (presc_next == '0);
    end
  end

  assign bus.dispDigit = seg_reg;
  assign bus.dispDP    = dp_out_reg;
  assign bus.selector  = selector_reg;
  assign bus.scan_tick = tick_reg;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux (4 digits, 8-cycle slots, 2-cycle guard, active-low).
// Expected per-slot displays are queued by the stimulus and checked by a tick-driven monitor.
module tb_seg_scan_mux;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BG = 2;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SDASH = 7'b0111111, SBLK = 7'b1111111;

  typedef struct {
    int         slot;
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  seg_scan_mux_if #(.NUM_DIGITS(ND)) bus();

  seg_scan_mux #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_GUARD(BG), .ACTIVE_LOW(1'b1)
`ifdef DISP_BLINK_EN
    , .BLINK_DIV(2)
`endif
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input int slot, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s slot %0d: got %0h expected %0h", name, slot, act, exp);
    end
  endtask

  function automatic logic [3:0] sel_of(input int j);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << j);
  endfunction

  task automatic push(input int slot, input logic [6:0] seg, input logic dp);
    exp_t e;
    e.slot = slot;
    e.sel  = sel_of(slot % ND);
    e.seg  = seg;
    e.dp   = dp;
    sb.push_back(e);
    $display("push slot %0d sel %b seg %b dp %b", slot, e.sel, seg, dp);
  endtask

  task automatic wait_at(input int s, input int k);
    while (cyc < 1 + SD * s + k) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sel"},  -1, 16'(bus.selector),  16'hF);
    chk({tag, "_seg"},  -1, 16'(bus.dispDigit), 16'h7F);
    chk({tag, "_dp"},   -1, 16'(bus.dispDP),    16'h1);
    chk({tag, "_tick"}, -1, 16'(bus.scan_tick), 16'h0);
  endtask

  // Monitor: slot numbers count scan_tick pulses since the last reset.
  initial begin
    int   slot_cnt;
    exp_t e;
    slot_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        slot_cnt = 0;
        continue;
      end
      if (bus.scan_tick !== 1'b1) continue;
      while (sb.size() > 0 && sb[0].slot < slot_cnt) begin
        e = sb.pop_front();
        chk("slot_missed", e.slot, 16'(slot_cnt), 16'(e.slot));
      end
      if (sb.size() > 0 && sb[0].slot == slot_cnt) begin
        e = sb.pop_front();
        chk("guard_sel_k0", e.slot, 16'(bus.selector), 16'hF);
        for (int k = 1; k < SD; k++) begin
          @(negedge clk);
          if (k == 1) begin
            chk("tick_low_k1", e.slot, 16'(bus.scan_tick), 16'h0);
            chk("guard_sel_k1", e.slot, 16'(bus.selector), 16'hF);
          end
          if (k == BG || k == SD - 1) begin
            chk("sel", e.slot, 16'(bus.selector), 16'(e.sel));
            chk("seg", e.slot, 16'(bus.dispDigit), 16'(e.seg));
            chk("dp", e.slot, 16'(bus.dispDP), 16'(e.dp));
          end
        end
        $display("slot %0d checked sel %b seg %b dp %b", e.slot, bus.selector, bus.dispDigit, bus.dispDP);
      end
      slot_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic dig0_lit;
    bus.digits      = 16'h1234;
    bus.dp          = '0;
    bus.lz_suppress = 1'b0;
`ifdef DISP_BLINK_EN
    bus.blink_mask  = '0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    for (int f = 0; f < 3; f++) begin
      push(4*f + 0, S4, 1'b1);
      push(4*f + 1, S3, 1'b1);
      push(4*f + 2, S2, 1'b1);
      push(4*f + 3, S1, 1'b1);
    end
    rst = 1'b0;

    // mid-frame change only appears from the next frame
    wait_at(9, 3);
    bus.digits = 16'h9999;
    for (int j = 0; j < 4; j++) push(12 + j, S9, 1'b1);

    wait_at(13, 3);
    bus.digits = 16'h0050;
    bus.lz_suppress = 1'b1;
    push(16, S0, 1'b1); push(17, S5, 1'b1); push(18, SBLK, 1'b1); push(19, SBLK, 1'b1);

    wait_at(17, 3);
    bus.digits = 16'h0000;
    push(20, S0, 1'b1); push(21, SBLK, 1'b1); push(22, SBLK, 1'b1); push(23, SBLK, 1'b1);

    wait_at(21, 3);
    bus.digits = 16'hB00A;
    bus.lz_suppress = 1'b0;
    bus.dp = 4'b0001;
    push(24, SDASH, 1'b0); push(25, S0, 1'b1); push(26, S0, 1'b1); push(27, SBLK, 1'b1);

    // suppressed digit 2 still shows its decimal point
    wait_at(25, 3);
    bus.digits = 16'h000B;
    bus.lz_suppress = 1'b1;
    bus.dp = 4'b0100;
    push(28, SBLK, 1'b1); push(29, SBLK, 1'b1); push(30, SBLK, 1'b0); push(31, SBLK, 1'b1);

    wait_at(29, 3);
    bus.digits = 16'h5678;
    bus.dp = '0;
    bus.lz_suppress = 1'b0;
`ifdef DISP_BLINK_EN
    bus.blink_mask = 4'b0001;
`endif

    wait_at(34, 3);
    chk("queue_drained", 34, 16'(sb.size()), 16'h0);
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    check_reset("midreset");
    for (int f = 0; f < 4; f++) begin
`ifdef DISP_BLINK_EN
      dig0_lit = (f < 2);
`else
      dig0_lit = 1'b1;
`endif
      push(4*f + 0, dig0_lit ? S8 : SBLK, 1'b1);
      push(4*f + 1, S7, 1'b1);
      push(4*f + 2, S6, 1'b1);
      push(4*f + 3, S5, 1'b1);
    end
    rst = 1'b0;

    n = 0;
    while (sb.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("final_drain", -1, 16'(sb.size()), 16'h0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
